qick_xcom_cmd_arb: RTL and testbench

QICK_XCOM_CMD_ARB -- requirements
Module: qick_xcom_cmd_arb

---
 rtl/qick_xcom_pkg.sv | 24 ++
 rtl/xcom_cmd_fifo.sv | 49 ++++
 rtl/qick_xcom_cmd_arb.sv | 142 ++++++++++++++
 tb/tb_qick_xcom_cmd_arb.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qick_xcom_pkg.sv
// Shared types for the XCOM command arbiter: FSM states, command record and
// the local-destination encoding.
package qick_xcom_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRel
    } xcom_state_e;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  dst;
        logic [31:0] dt;
    } xcom_cmd_t;

    localparam logic [3:0]  LOC_DST = 4'd0;
    localparam int unsigned CNT_W   = 4;

    function automatic logic is_local(input xcom_cmd_t cmd);
        return cmd.dst == LOC_DST;
    endfunction

endpackage

// File: rtl/xcom_cmd_fifo.sv
// Per-source command queue. A push on a full queue is taken only when a pop
// happens in the same cycle.
module xcom_cmd_fifo
    import qick_xcom_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = xcom_cmd_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic pop_i,
    input  T     din_i,
    output T     dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/qick_xcom_cmd_arb.sv
// Arbitrates per-source command queues onto a single local/network
// req/ack handshake, with round-robin or fixed-priority selection.
module qick_xcom_cmd_arb
    import qick_xcom_pkg::*;
#(
    parameter int unsigned N_SRC = 2,
    parameter int unsigned QD    = 4,
    parameter int unsigned RR    = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_SRC-1:0]           src_vld_i,
    input  logic [N_SRC*5-1:0]         src_op_i,
    input  logic [N_SRC*4-1:0]         src_dst_i,
    input  logic [N_SRC*32-1:0]        src_dt_i,
    output logic [N_SRC-1:0]           src_full_o,
    output logic                       cmd_loc_req_o,
    input  logic                       cmd_loc_ack_i,
    output logic                       cmd_net_req_o,
    input  logic                       cmd_net_ack_i,
    output logic [4:0]                 cmd_op_o,
    output logic [3:0]                 cmd_dst_o,
    output logic [31:0]                cmd_dt_o,
    output logic [$clog2(N_SRC)-1:0]   cmd_src_o,
    output logic [N_SRC-1:0]           ovf_o,
    output logic [N_SRC*CNT_W-1:0]     cmd_cnt_do
);
    localparam int unsigned SW = $clog2(N_SRC);

    xcom_cmd_t        head [N_SRC];
    logic [N_SRC-1:0] full;
    logic [N_SRC-1:0] empty;
    logic [N_SRC-1:0] pop;

    xcom_state_e      state_q;
    xcom_cmd_t        cmd_q;
    logic [SW-1:0]    src_q;
    logic [SW-1:0]    rr_ptr_q;
    logic             loc_req_q;
    logic             net_req_q;
    logic [CNT_W-1:0] cnt_q [N_SRC];
    logic [N_SRC-1:0] ovf_q;

    logic             gnt_vld;
    logic [SW-1:0]    gnt_idx;
    logic [SW-1:0]    cand;
    logic [SW-1:0]    rr_nxt;
    logic             ack;

    for (genvar s = 0; s < N_SRC; s++) begin : g_src
        xcom_cmd_t din;
        assign din = '{op: src_op_i[s*5 +: 5], dst: src_dst_i[s*4 +: 4], dt: src_dt_i[s*32 +: 32]};

        xcom_cmd_fifo #(
            .DEPTH (QD),
            .T     (xcom_cmd_t)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (src_vld_i[s]),
            .pop_i   (pop[s]),
            .din_i   (din),
            .dout_o  (head[s]),
            .full_o  (full[s]),
            .empty_o (empty[s])
        );

        assign pop[s] = (state_q == StIdle) && gnt_vld && (gnt_idx == SW'(s));
        assign cmd_cnt_do[s*CNT_W +: CNT_W] = cnt_q[s];
    end

    // Scan downwards so the last hit is the first candidate in search order.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (RR != 0) cand = SW'((int'(rr_ptr_q) + k) % N_SRC);
            else         cand = SW'(k);
            if (!empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign rr_nxt = (gnt_idx == SW'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    assign ack    = is_local(cmd_q) ? cmd_loc_ack_i : cmd_net_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            src_q     <= '0;
            rr_ptr_q  <= '0;
            loc_req_q <= 1'b0;
            net_req_q <= 1'b0;
            for (int s = 0; s < N_SRC; s++) cnt_q[s] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_vld) begin
                        cmd_q          <= head[gnt_idx];
                        src_q          <= gnt_idx;
                        rr_ptr_q       <= rr_nxt;
                        cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 1'b1;
                        loc_req_q      <= is_local(head[gnt_idx]);
                        net_req_q      <= !is_local(head[gnt_idx]);
                        state_q        <= StReq;
                    end
                end
                StReq: begin
                    if (ack) begin
                        loc_req_q <= 1'b0;
                        net_req_q <= 1'b0;
                        state_q   <= StRel;
                    end
                end
                StRel: begin
                    if (!ack) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Overflow only when the strobe is not rescued by a same-cycle pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) ovf_q <= '0;
        else       ovf_q <= ovf_q | (src_vld_i & full & ~pop);
    end

    assign src_full_o    = full;
    assign ovf_o         = ovf_q;
    assign cmd_loc_req_o = loc_req_q;
    assign cmd_net_req_o = net_req_q;
    assign cmd_op_o      = cmd_q.op;
    assign cmd_dst_o     = cmd_q.dst;
    assign cmd_dt_o      = cmd_q.dt;
    assign cmd_src_o     = src_q;

endmodule

// File: tb/tb_qick_xcom_cmd_arb.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share source
// stimulus; a queue-level model predicts grants, a negedge monitor checks.
module tb_qick_xcom_cmd_arb;
    localparam int NS  = 4;
    localparam int QDP = 4;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  dst;
        logic [31:0] dt;
    } cmd_t;

    typedef struct packed {
        logic [1:0] src;
        cmd_t       c;
    } exp_t;

    bit clk;
    logic rst;
    logic [NS-1:0]    src_vld;
    logic [NS*5-1:0]  src_op;
    logic [NS*4-1:0]  src_dst;
    logic [NS*32-1:0] src_dt;

    logic [NS-1:0] full [2];
    logic [NS-1:0] ovf [2];
    logic          loc_req [2];
    logic          net_req [2];
    logic          loc_ack [2];
    logic          net_ack [2];
    logic [4:0]    op_o [2];
    logic [3:0]    dst_o [2];
    logic [31:0]   dt_o [2];
    logic [1:0]    src_o [2];
    logic [15:0]   cnt [2];

    int checks = 0;
    int errors = 0;
    bit ack_auto = 1'b0;

    always #5 clk = ~clk;

    qick_xcom_cmd_arb #(.N_SRC(NS), .QD(QDP), .RR(1)) u_rr (
        .clk_i(clk), .rst_i(rst), .src_vld_i(src_vld), .src_op_i(src_op),
        .src_dst_i(src_dst), .src_dt_i(src_dt), .src_full_o(full[0]),
        .cmd_loc_req_o(loc_req[0]), .cmd_loc_ack_i(loc_ack[0]),
        .cmd_net_req_o(net_req[0]), .cmd_net_ack_i(net_ack[0]),
        .cmd_op_o(op_o[0]), .cmd_dst_o(dst_o[0]), .cmd_dt_o(dt_o[0]),
        .cmd_src_o(src_o[0]), .ovf_o(ovf[0]), .cmd_cnt_do(cnt[0])
    );

    qick_xcom_cmd_arb #(.N_SRC(NS), .QD(QDP), .RR(0)) u_fp (
        .clk_i(clk), .rst_i(rst), .src_vld_i(src_vld), .src_op_i(src_op),
        .src_dst_i(src_dst), .src_dt_i(src_dt), .src_full_o(full[1]),
        .cmd_loc_req_o(loc_req[1]), .cmd_loc_ack_i(loc_ack[1]),
        .cmd_net_req_o(net_req[1]), .cmd_net_ack_i(net_ack[1]),
        .cmd_op_o(op_o[1]), .cmd_dst_o(dst_o[1]), .cmd_dt_o(dt_o[1]),
        .cmd_src_o(src_o[1]), .ovf_o(ovf[1]), .cmd_cnt_do(cnt[1])
    );

    // Reference model: per-source queues plus a three-phase handshake
    // (0 idle, 1 requesting, 2 releasing). Index 0 is round-robin.
    cmd_t m_q [2][NS][QDP];
    int   m_n [2][NS];
    int   m_issued [2][NS];
    bit   m_ovf [2][NS];
    int   m_phase [2];
    cmd_t m_cur [2];
    int   m_src [2];
    int   m_last [2];
    bit   m_fresh [2];
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];
    int   order0 [$];
    int   order1 [$];
    bit   prev_req [2];

    task automatic chk(input string name, input int d, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h", name, d, got, want);
        end
    endtask

    task automatic model_step(input int d);
        int   sel;
        int   s;
        bit   ack;
        cmd_t c;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_n[d][i] = 0; m_issued[d][i] = 0; m_ovf[d][i] = 1'b0;
            end
            m_phase[d] = 0; m_cur[d] = '0; m_src[d] = 0; m_last[d] = NS - 1;
            m_fresh[d] = 1'b1;
            if (d == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        ack = (m_cur[d].dst == 4'd0) ? loc_ack[d] : net_ack[d];
        if (m_phase[d] == 0) begin
            sel = -1;
            for (int k = 0; k < NS; k++) begin
                s = (d == 0) ? (m_last[d] + 1 + k) % NS : k;
                if (sel < 0 && m_n[d][s] > 0) sel = s;
            end
            if (sel >= 0) begin
                m_cur[d] = m_q[d][sel][0];
                for (int j = 0; j < QDP - 1; j++) m_q[d][sel][j] = m_q[d][sel][j+1];
                m_n[d][sel]--;
                m_phase[d] = 1; m_src[d] = sel; m_last[d] = sel; m_fresh[d] = 1'b0;
                m_issued[d][sel]++;
                if (d == 0) exp_q0.push_back({2'(sel), m_cur[d]});
                else        exp_q1.push_back({2'(sel), m_cur[d]});
            end
        end else if (m_phase[d] == 1) begin
            if (ack) m_phase[d] = 2;
        end else if (!ack) begin
            m_phase[d] = 0;
        end
        for (int i = 0; i < NS; i++) begin
            if (src_vld[i]) begin
                c = '{op: src_op[i*5 +: 5], dst: src_dst[i*4 +: 4], dt: src_dt[i*32 +: 32]};
                if (m_n[d][i] < QDP) begin
                    m_q[d][i][m_n[d][i]] = c;
                    m_n[d][i]++;
                end else begin
                    m_ovf[d][i] = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic mon(input int d);
        logic [NS-1:0] ef;
        logic [NS-1:0] eo;
        logic [15:0]   ec;
        bit            eloc;
        exp_t          e;
        bit            have;
        for (int s = 0; s < NS; s++) begin
            ef[s] = (m_n[d][s] == QDP);
            eo[s] = m_ovf[d][s];
            ec[s*4 +: 4] = 4'(m_issued[d][s] % 16);
        end
        eloc = (m_cur[d].dst == 4'd0);
        chk("loc_req", d, 64'(loc_req[d]), 64'(m_phase[d] == 1 && eloc));
        chk("net_req", d, 64'(net_req[d]), 64'(m_phase[d] == 1 && !eloc));
        chk("src_full", d, 64'(full[d]), 64'(ef));
        chk("ovf", d, 64'(ovf[d]), 64'(eo));
        chk("cmd_cnt", d, 64'(cnt[d]), 64'(ec));
        if (m_phase[d] != 0 || m_fresh[d])
            chk("cmd_fields", d, 64'({src_o[d], op_o[d], dst_o[d], dt_o[d]}),
                64'({2'(m_src[d]), m_cur[d]}));
        if ((loc_req[d] || net_req[d]) && !prev_req[d]) begin
            have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
            if (!have) begin
                chk("unexpected_req", d, 64'd1, 64'd0);
            end else begin
                e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk("issue", d, 64'({src_o[d], op_o[d], dst_o[d], dt_o[d]}), 64'(e));
                if (d == 0) order0.push_back(int'(src_o[0]));
                else        order1.push_back(int'(src_o[1]));
            end
        end
        prev_req[d] = loc_req[d] || net_req[d];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic tick();
        @(negedge clk);
        if (ack_auto) begin
            for (int d = 0; d < 2; d++) begin
                loc_ack[d] = loc_req[d] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
                net_ack[d] = net_req[d] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
            end
        end
        src_vld = '0;
    endtask

    task automatic set_acks(input logic l, input logic n);
        for (int d = 0; d < 2; d++) begin
            loc_ack[d] = l;
            net_ack[d] = n;
        end
    endtask

    task automatic strobe(input int s, input logic [4:0] op, input logic [3:0] dst,
                          input logic [31:0] dt);
        src_vld[s]          = 1'b1;
        src_op[s*5 +: 5]    = op;
        src_dst[s*4 +: 4]   = dst;
        src_dt[s*32 +: 32]  = dt;
    endtask

    function automatic bit quiet();
        bit q = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (m_phase[d] != 0) q = 1'b0;
            for (int s = 0; s < NS; s++) if (m_n[d][s] != 0) q = 1'b0;
        end
        return q;
    endfunction

    task automatic wait_idle(input int maxc);
        int c = 0;
        do begin
            tick();
            c++;
        end while (!quiet() && c < maxc);
        chk("drain_in_budget", 0, 64'(quiet()), 64'd1);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_order(input string name, input int d, input int e0, input int e1,
                             input int e2, input int e3);
        int q [$];
        int e [4];
        e = '{e0, e1, e2, e3};
        if (d == 0) q = order0; else q = order1;
        chk(name, d, 64'(q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < q.size()) chk(name, d, 64'(q[i]), 64'(e[i]));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog dut0 got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; src_vld = '0; src_op = '0; src_dst = '0; src_dt = '0;
        set_acks(1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_reqs", d, 64'({loc_req[d], net_req[d]}), 64'd0);
            chk("rst_fields", d, 64'({src_o[d], op_o[d], dst_o[d], dt_o[d]}), 64'd0);
            chk("rst_cnt", d, 64'(cnt[d]), 64'd0);
        end

        // Local command: two-cycle latency, ack handshake, count of one.
        tick();
        strobe(0, 5'h03, 4'h0, 32'hA5A5_0001);
        tick();
        for (int d = 0; d < 2; d++) chk("lat_not_1", d, 64'(loc_req[d]), 64'd0);
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("loc_req_on", d, 64'(loc_req[d]), 64'd1);
            chk("net_req_off", d, 64'(net_req[d]), 64'd0);
        end
        set_acks(1'b1, 1'b0);
        tick();
        for (int d = 0; d < 2; d++) chk("req_drop", d, 64'(loc_req[d]), 64'd0);
        set_acks(1'b0, 1'b0);
        tick();
        for (int d = 0; d < 2; d++) chk("cnt0_one", d, 64'(cnt[d][3:0]), 64'd1);

        // All four sources at once, network destination.
        do_reset();
        ack_auto = 1'b1;
        order0.delete(); order1.delete();
        tick();
        for (int s = 0; s < NS; s++) strobe(s, 5'(s + 1), 4'h2, 32'h1000 + s);
        wait_idle(200);
        chk_order("rr_order", 0, 0, 1, 2, 3);
        chk_order("fp_order4", 1, 0, 1, 2, 3);

        // Two entries each on sources 0 and 1.
        order0.delete(); order1.delete();
        tick();
        strobe(0, 5'h0A, 4'h0, 32'h2000_0000); strobe(1, 5'h0B, 4'h5, 32'h2100_0000);
        tick();
        strobe(0, 5'h0C, 4'h3, 32'h2000_0001); strobe(1, 5'h0D, 4'h0, 32'h2100_0001);
        wait_idle(300);
        chk_order("rr_alt", 0, 0, 1, 0, 1);
        chk_order("fp_prio", 1, 0, 0, 1, 1);

        // Overflow with acks held low.
        ack_auto = 1'b0;
        tick();
        set_acks(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            strobe(0, 5'(i), 4'h1, 32'hC0DE_0000 + i);
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            chk("ovf_full", d, 64'(full[d][0]), 64'd1);
            chk("ovf_not_yet", d, 64'(ovf[d][0]), 64'd0);
        end
        strobe(0, 5'h1F, 4'h1, 32'hDEAD_BEEF);
        tick();
        for (int d = 0; d < 2; d++) chk("ovf_set", d, 64'(ovf[d][0]), 64'd1);
        ack_auto = 1'b1;
        wait_idle(400);

        // Reset while requesting, with a second command queued behind it.
        ack_auto = 1'b0;
        tick();
        set_acks(1'b0, 1'b0);
        strobe(0, 5'h07, 4'h0, 32'h3000_0000); strobe(1, 5'h08, 4'h0, 32'h3100_0000);
        tick();
        tick();
        for (int d = 0; d < 2; d++) chk("pre_rst_req", d, 64'(loc_req[d]), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_drop", d, 64'({loc_req[d], net_req[d]}), 64'd0);
            chk("rst_full", d, 64'(full[d]), 64'd0);
            chk("rst_ovf", d, 64'(ovf[d]), 64'd0);
            chk("rst_cnt2", d, 64'(cnt[d]), 64'd0);
        end
        tick();
        for (int d = 0; d < 2; d++) chk("queues_flushed", d, 64'(loc_req[d]), 64'd0);
        strobe(0, 5'h09, 4'h3, 32'h3200_0000);
        tick();
        tick();
        for (int d = 0; d < 2; d++)
            chk("post_rst_issue", d, 64'({net_req[d], src_o[d], dt_o[d]}),
                64'({1'b1, 2'd0, 32'h3200_0000}));
        ack_auto = 1'b1;
        wait_idle(100);

        // Counter wrap after 17 grants.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            strobe(0, 5'($urandom), 4'h0, $urandom);
            wait_idle(100);
        end
        for (int d = 0; d < 2; d++) chk("cnt_wrap", d, 64'(cnt[d][3:0]), 64'd1);

        // Network ack during a local request is ignored.
        ack_auto = 1'b0;
        tick();
        set_acks(1'b0, 1'b0);
        strobe(0, 5'h04, 4'h0, 32'h4000_0000);
        tick();
        tick();
        set_acks(1'b0, 1'b1);
        tick();
        for (int d = 0; d < 2; d++) chk("wrong_ack_hold", d, 64'(loc_req[d]), 64'd1);
        set_acks(1'b0, 1'b0);
        tick();
        for (int d = 0; d < 2; d++) chk("wrong_ack_hold2", d, 64'(loc_req[d]), 64'd1);
        set_acks(1'b1, 1'b0);
        tick();
        for (int d = 0; d < 2; d++) chk("right_ack_drop", d, 64'(loc_req[d]), 64'd0);
        ack_auto = 1'b1;
        wait_idle(100);

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            tick();
            rst = ($urandom_range(0, 399) == 0);
            for (int s = 0; s < NS; s++)
                if ($urandom_range(0, 3) == 0)
                    strobe(s, 5'($urandom), ($urandom_range(0, 1) == 0) ? 4'h0
                           : 4'($urandom_range(1, 15)), $urandom);
        end
        tick();
        rst = 1'b0;
        wait_idle(800);
        chk("sb_empty", 0, 64'(exp_q0.size()), 64'd0);
        chk("sb_empty", 1, 64'(exp_q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
